// File: rtl/rect_fall_ctrl.sv
// rect_fall_ctrl: position controller for the falling/bouncing rectangle.
// While idle the rectangle follows the mouse. A left-button press drops it
// under constant gravity onto a floor. When the bounce build is enabled it
// rebounds with a fixed velocity loss per impact until it comes to rest.
// Build option: define RECT_FALL_BOUNCE_EN to enable bouncing. When it is
// undefined, the rectangle stops at the first floor impact.
module rect_fall_ctrl #(
  parameter int STEP_CYCLES = 400_000,
  parameter int GRAV        = 1,
  parameter int LOSS        = 2,
  parameter int V_MAX       = 63,
  parameter int FLOOR_Y     = 537
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos_in,
  input  logic [11:0] ypos_in,
  input  logic        start,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    DOWN   = 3'b001,
    UP     = 3'b010,
    BOTTOM = 3'b011,
    REST   = 3'b100
  } state_t;

`ifdef RECT_FALL_BOUNCE_EN
  localparam logic BOUNCE_EN = 1'b1;
`else
  localparam logic BOUNCE_EN = 1'b0;
`endif

  localparam int             CW       = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [8:0]     GRAV9    = 9'(GRAV);
  localparam logic [7:0]     GRAV8    = 8'(GRAV);
  localparam logic [7:0]     LOSS8    = 8'(LOSS);
  localparam logic [8:0]     VMAX9    = 9'(V_MAX);
  localparam logic [12:0]    FLOOR13  = 13'(FLOOR_Y);
  localparam logic [11:0]    FLOOR12  = 12'(FLOOR_Y);

  state_t        state_reg, state_next;
  logic [11:0]   xpos_reg, xpos_next;
  logic [11:0]   ypos_reg, ypos_next;
  logic [7:0]    vel_reg, vel_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          start_d_reg;

  logic          start_edge;
  logic          tick;
  logic [8:0]    vel_sum;
  logic [8:0]    vel_fall;
  logic [12:0]   y_fall;
  logic [7:0]    vel_loss;
  logic [7:0]    vel_rise;

  assign start_edge = start & ~start_d_reg;
  assign tick       = (cnt_reg == CNT_LAST);

  // Falling step: saturated velocity, then position computed one bit wider
  // so the floor comparison cannot wrap.
  assign vel_sum  = {1'b0, vel_reg} + GRAV9;
  assign vel_fall = (vel_sum > VMAX9) ? VMAX9 : vel_sum;
  assign y_fall   = {1'b0, ypos_reg} + {4'b0, vel_fall};

  // Velocity after the floor impact and after one rising step, floored at 0.
  assign vel_loss = (vel_reg > LOSS8) ? (vel_reg - LOSS8) : 8'd0;
  assign vel_rise = (vel_reg > GRAV8) ? (vel_reg - GRAV8) : 8'd0;

  assign xpos  = xpos_reg;
  assign ypos  = ypos_reg;
  assign state = state_reg;

  // State, position, velocity, step counter and button history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      xpos_reg    <= '0;
      ypos_reg    <= '0;
      vel_reg     <= '0;
      cnt_reg     <= '0;
      start_d_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      xpos_reg    <= xpos_next;
      ypos_reg    <= ypos_next;
      vel_reg     <= vel_next;
      cnt_reg     <= cnt_next;
      start_d_reg <= start;
    end
  end

  // Next-state and motion update; the counter restarts on every transition.
  always_comb begin
    state_next = state_reg;
    xpos_next  = xpos_reg;
    ypos_next  = ypos_reg;
    vel_next   = vel_reg;
    cnt_next   = '0;

    case (state_reg)
      IDLE: begin
        ypos_next = (ypos_in > FLOOR12) ? FLOOR12 : ypos_in;
        if (start_edge) begin
          state_next = DOWN;
          vel_next   = 8'd0;
        end else begin
          xpos_next = xpos_in;
        end
      end

      DOWN: begin
        if (tick) begin
          vel_next = vel_fall[7:0];
          if (y_fall >= FLOOR13) begin
            ypos_next  = FLOOR12;
            state_next = BOTTOM;
          end else begin
            ypos_next = y_fall[11:0];
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      BOTTOM: begin
        vel_next   = BOUNCE_EN ? vel_loss : 8'd0;
        state_next = (BOUNCE_EN && (vel_loss != 8'd0)) ? UP : REST;
      end

      UP: begin
        if (tick) begin
          if ({4'b0, vel_reg} >= ypos_reg) begin
            // Ceiling reached: stop at the top edge and fall back down.
            ypos_next  = 12'd0;
            vel_next   = 8'd0;
            state_next = DOWN;
          end else begin
            ypos_next = ypos_reg - {4'b0, vel_reg};
            vel_next  = vel_rise;
            if (vel_rise == 8'd0) begin
              state_next = DOWN;
            end
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      REST: begin
        if (start_edge) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
